// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: fixed-point format, saturation bounds and
// the accumulator FSM state encoding.
package snn_pkg;

  localparam int unsigned ACC_BITS  = 8;
  localparam int unsigned FRAC_BITS = 6;

  // Saturation bounds of the signed <ACC_BITS,FRAC_BITS> format.
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  // Fixed-point 1.0, the value of a single input spike.
  localparam logic signed [ACC_BITS-1:0] ONE = ACC_BITS'(1 << FRAC_BITS);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } acc_state_e;

endpackage

// File: rtl/syn_accum_if.sv
// Spike-vector input stream, weight-memory read port and current output
// stream of the synaptic accumulator.
interface syn_accum_if #(
  parameter int unsigned ACC_BITS  = 8,
  parameter int unsigned IN_COUNT  = 4,
  parameter int unsigned OUT_COUNT = 3
);
  localparam int unsigned ADDR_BITS = $clog2(IN_COUNT * OUT_COUNT);
  localparam int unsigned IDX_BITS  = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;

  logic                       in_valid;
  logic                       in_ready;
  logic [IN_COUNT-1:0]        in_spk;
  logic                       w_en;
  logic [ADDR_BITS-1:0]       w_addr;
  logic signed [ACC_BITS-1:0] w_data;
  logic                       cur_valid;
  logic                       cur_ready;
  logic signed [ACC_BITS-1:0] cur_data;
  logic [IDX_BITS-1:0]        cur_idx;
  logic                       cur_last;

  // The accumulator block itself.
  modport slave (
    input  in_valid, in_spk, w_data, cur_ready,
    output in_ready, w_en, w_addr, cur_valid, cur_data, cur_idx, cur_last
  );

  // The environment: spike source, weight memory and LIF consumer.
  modport master (
    output in_valid, in_spk, w_data, cur_ready,
    input  in_ready, w_en, w_addr, cur_valid, cur_data, cur_idx, cur_last
  );

endinterface

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the representable range instead
// of wrapping. Shared with the LIF membrane update.
module sat_add import snn_pkg::*; #(
  parameter int unsigned W = snn_pkg::ACC_BITS
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  logic [W:0] sum_ext;

  // One guard bit detects overflow; its sign picks the clamp direction.
  always_comb begin
    sum_ext = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    if (sum_ext[W] != sum_ext[W-1]) begin
      sum_o = sum_ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum_o = sum_ext[W-1:0];
    end
  end

endmodule

// File: rtl/syn_accum.sv
// Synaptic current accumulator. For each output neuron, serially reads the
// weights of all inputs and sums those whose input spiked, with per-step
// saturation, then hands the current to the LIF stage on a valid/ready stream.
module syn_accum import snn_pkg::*; #(
  parameter int unsigned ACC_BITS  = snn_pkg::ACC_BITS,
  parameter int unsigned FRAC_BITS = snn_pkg::FRAC_BITS,
  parameter int unsigned IN_COUNT  = 4,
  parameter int unsigned OUT_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  syn_accum_if.slave bus
);

  localparam int unsigned ADDR_BITS = $clog2(IN_COUNT * OUT_COUNT);
  localparam int unsigned IDX_BITS  = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam int unsigned CNT_BITS  = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;

  localparam logic [CNT_BITS-1:0] I_LAST = CNT_BITS'(IN_COUNT - 1);
  localparam logic [IDX_BITS-1:0] J_LAST = IDX_BITS'(OUT_COUNT - 1);

  if (FRAC_BITS >= ACC_BITS) begin : g_bad_format
    $error("FRAC_BITS must leave at least a sign bit");
  end

  acc_state_e                 state_q;
  logic [IN_COUNT-1:0]        spk_q;
  logic [IDX_BITS-1:0]        j_q;
  logic [CNT_BITS-1:0]        i_q;      // input index of the read on the bus
  logic [CNT_BITS-1:0]        ridx_q;   // input index of the data now on w_data
  logic                       rvld_q;   // w_data carries a requested weight
  logic signed [ACC_BITS-1:0] acc_q;
  logic signed [ACC_BITS-1:0] acc_sum;
  logic                       in_ready_q;
  logic                       w_en_q;
  logic [ADDR_BITS-1:0]       w_addr_q;
  logic                       cur_valid_q;
  logic                       cur_last_q;
  logic [ADDR_BITS-1:0]       next_base;

  sat_add #(
    .W(ACC_BITS)
  ) u_sat_add (
    .a_i  (acc_q),
    .b_i  (bus.w_data),
    .sum_o(acc_sum)
  );

  // First weight address of the following neuron.
  assign next_base = ADDR_BITS'((32'(j_q) + 32'd1) * IN_COUNT);

  // Sequencer: issue IN_COUNT reads, drain the last one, present the current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      spk_q       <= '0;
      j_q         <= '0;
      i_q         <= '0;
      ridx_q      <= '0;
      rvld_q      <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      cur_valid_q <= 1'b0;
      cur_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            spk_q      <= bus.in_spk;
            j_q        <= '0;
            i_q        <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            w_en_q     <= 1'b1;
            w_addr_q   <= '0;
            state_q    <= StAcc;
          end
        end
        StAcc: begin
          rvld_q <= w_en_q;
          ridx_q <= i_q;
          if (rvld_q && spk_q[ridx_q]) begin
            acc_q <= acc_sum;
          end
          if (w_en_q) begin
            if (i_q == I_LAST) begin
              w_en_q   <= 1'b0;
              w_addr_q <= '0;
            end else begin
              i_q      <= i_q + 1'b1;
              w_addr_q <= w_addr_q + 1'b1;
            end
          end else begin
            // Drain cycle: the last weight is folded in on this same edge.
            state_q     <= StOut;
            cur_valid_q <= 1'b1;
            cur_last_q  <= (j_q == J_LAST);
          end
        end
        StOut: begin
          if (bus.cur_ready) begin
            cur_valid_q <= 1'b0;
            cur_last_q  <= 1'b0;
            if (j_q == J_LAST) begin
              j_q        <= '0;
              in_ready_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              j_q      <= j_q + 1'b1;
              i_q      <= '0;
              acc_q    <= '0;
              w_en_q   <= 1'b1;
              w_addr_q <= next_base;
              state_q  <= StAcc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.cur_valid = cur_valid_q;
  assign bus.cur_data  = acc_q;
  assign bus.cur_idx   = j_q;
  assign bus.cur_last  = cur_last_q;

endmodule

// File: tb/tb_syn_accum.sv
// Randomised and directed bench for syn_accum with a weight-memory model and a
// queue-based scoreboard.
module tb_syn_accum;
  import snn_pkg::*;

  localparam int unsigned IN_N  = 4;
  localparam int unsigned OUT_N = 3;
  localparam int          LAT   = IN_N + 1;

  typedef struct {
    logic [7:0] data;
    int         idx;
    int         last;
  } exp_t;

  logic clk;
  logic rst_n;

  syn_accum_if #(.ACC_BITS(8), .IN_COUNT(IN_N), .OUT_COUNT(OUT_N)) bus ();

  syn_accum #(
    .ACC_BITS (8),
    .FRAC_BITS(6),
    .IN_COUNT (IN_N),
    .OUT_COUNT(OUT_N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [IN_N*OUT_N];
  exp_t       exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous weight memory, one cycle read latency.
  always @(posedge clk) begin
    if (bus.w_en) bus.w_data <= mem[bus.w_addr];
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout/unexpected event, required normal progress (t=%0t)",
             name, $time);
  endtask

  // Reference: sum of spiking weights, clamped to the 8-bit range after every add.
  function automatic logic [7:0] ref_cur(input int j, input logic [IN_N-1:0] spk);
    int s = 0;
    for (int i = 0; i < IN_N; i++) begin
      if (spk[i]) begin
        s = s + int'($signed(mem[j*IN_N+i]));
        if (s > 127) s = 127;
        if (s < -128) s = -128;
      end
    end
    return 8'(s);
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input int j);
    exp_t e;
    e.data = d;
    e.idx  = j;
    e.last = (j == OUT_N - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic set_neuron(input int j, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
    mem[j*IN_N+0] = w0;
    mem[j*IN_N+1] = w1;
    mem[j*IN_N+2] = w2;
    mem[j*IN_N+3] = w3;
  endtask

  // Offer a vector until accepted; push either model or directed expectations.
  task automatic send_vec(input logic [IN_N-1:0] spk, input bit use_model,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_spk   = spk;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      fail("in_accept");
    end else begin
      t_start = cyc;
      if (use_model) begin
        for (int j = 0; j < OUT_N; j++) exp_q.push_back(mk(ref_cur(j, spk), j));
      end else begin
        exp_q.push_back(mk(e0, 0));
        exp_q.push_back(mk(e1, 1));
        exp_q.push_back(mk(e2, 2));
      end
    end
    bus.in_valid = 1'b0;
    bus.in_spk   = IN_N'($urandom);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && bus.in_ready;
    end
    if (!ok) fail("drain");
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    bus.cur_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.cur_ready = 1'b1;
        1:       bus.cur_ready = ($urandom_range(0, 9) < 7);
        default: bus.cur_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-under-backpressure, latency, in_ready timing.
  initial begin
    logic       pv  = 1'b0;
    logic       pr  = 1'b0;
    logic       pin = 1'b1;
    logic [7:0] pd  = '0;
    int         pi  = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv  = 1'b0;
        pin = 1'b1;
        continue;
      end
      if (pv && !pr) begin
        check("hold_valid", int'(bus.cur_valid), 1);
        check("hold_data", {24'd0, bus.cur_data}, {24'd0, pd});
        check("hold_idx", int'(bus.cur_idx), pi);
      end
      if (bus.cur_valid) check("w_en_in_out", int'(bus.w_en), 0);
      if (bus.cur_valid && !pv) check("latency", cyc - t_start, LAT);
      if (bus.cur_valid && bus.cur_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_cur");
        end else begin
          e = exp_q.pop_front();
          check("cur_data", {24'd0, bus.cur_data}, {24'd0, e.data});
          check("cur_idx", int'(bus.cur_idx), e.idx);
          check("cur_last", int'(bus.cur_last), e.last);
        end
        t_start = cyc + 1;
      end
      if (bus.in_ready && !pin) check("in_ready_early", exp_q.size(), 0);
      pv  = bus.cur_valid;
      pr  = bus.cur_ready;
      pd  = bus.cur_data;
      pi  = int'(bus.cur_idx);
      pin = bus.in_ready;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check({tag, "_w_en"}, int'(bus.w_en), 0);
    check({tag, "_w_addr"}, int'(bus.w_addr), 0);
    check({tag, "_cur_valid"}, int'(bus.cur_valid), 0);
    check({tag, "_cur_data"}, {24'd0, bus.cur_data}, 0);
    check({tag, "_cur_idx"}, int'(bus.cur_idx), 0);
    check({tag, "_cur_last"}, int'(bus.cur_last), 0);
  endtask

  initial begin
    bit seen;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_spk   = '0;
    for (int k = 0; k < IN_N*OUT_N; k++) mem[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("post_rst");

    // Basic sum and per-neuron saturation.
    set_neuron(0, 8'h10, 8'h10, 8'h10, 8'h10);
    set_neuron(1, 8'h60, 8'h60, 8'h60, 8'h60);
    set_neuron(2, 8'hA0, 8'hA0, 8'hA0, 8'hA0);
    send_vec(4'b1111, 1'b0, 8'h40, 8'h7F, 8'h80);
    wait_idle();

    // Sparse spikes.
    send_vec(4'b0101, 1'b0, 8'h20, 8'h7F, 8'h80);
    wait_idle();

    // Clamp happens per add: 0x60+0x60 -> 0x7F, then +0xA0 -> 0x1F.
    set_neuron(0, 8'h60, 8'h60, 8'hA0, 8'h00);
    send_vec(4'b1111, 1'b0, 8'h1F, 8'h7F, 8'h80);
    wait_idle();

    // All-zero spikes.
    send_vec(4'b0000, 1'b0, 8'h00, 8'h00, 8'h00);
    wait_idle();

    // Backpressure on the first current.
    rdy_mode = 2;
    send_vec(4'b1111, 1'b0, 8'h1F, 8'h7F, 8'h80);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = bus.cur_valid;
    end
    if (!seen) fail("bp_valid");
    repeat (6) @(posedge clk);
    #1;
    check("bp_held_valid", int'(bus.cur_valid), 1);
    check("bp_held_idx", int'(bus.cur_idx), 0);
    rdy_mode = 0;
    wait_idle();

    // Busy input is ignored.
    set_neuron(0, 8'h10, 8'h10, 8'h10, 8'h10);
    send_vec(4'b1111, 1'b0, 8'h40, 8'h7F, 8'h80);
    bus.in_valid = 1'b1;
    bus.in_spk   = 4'b0000;
    @(posedge clk);
    #1;
    check("busy_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();

    // Reset during neuron 1 accumulation.
    send_vec(4'b1111, 1'b0, 8'h40, 8'h7F, 8'h80);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = (exp_q.size() == 2);
    end
    if (!seen) fail("rst_mid_wait");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_in_ready", int'(bus.in_ready), 1);
    check("rst_mid_cur_valid", int'(bus.cur_valid), 0);
    check("rst_mid_w_en", int'(bus.w_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_vec(4'b0101, 1'b0, 8'h20, 8'h7F, 8'h80);
    wait_idle();

    // Random weights, spikes, gaps and downstream stalls against the model.
    rdy_mode = 1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < IN_N*OUT_N; k++) mem[k] = 8'($urandom);
      for (int v = 0; v < 8; v++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_vec(IN_N'($urandom), 1'b1, 8'h00, 8'h00, 8'h00);
      end
      wait_idle();
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
